// File: rtl/online_sd_sequencer.sv
// Operand/result sequencer for an on-line signed-digit divider.
// Latches dividend and divisor digit vectors on start, streams them MSD first
// (one digit pair per digit_req), then pads with zeros while the divider
// drains. Quotient digits are shifted in as they arrive, and the assembled
// quotient is published with a one-cycle done pulse once N digits are in.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, abort                begin a transfer / cancel the current one
//   x_plus/x_minus              dividend digit vectors, bit N-1 = MSD
//   d_plus/d_minus              divisor digit vectors, bit N-1 = MSD
//   digit_req                   divider asks for the next operand digit pair
//   x_digit, d_digit            streamed digits {plus,minus}, registered
//   q_digit, q_valid            quotient digit from the divider
//   q_plus, q_minus             assembled quotient, bit N-1 = MSD
//   busy, done, err             active / completion pulse / sticky encoding error
module online_sd_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned DELTA = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] x_plus,
  input  logic [N-1:0] x_minus,
  input  logic [N-1:0] d_plus,
  input  logic [N-1:0] d_minus,
  input  logic         digit_req,
  output logic [1:0]   x_digit,
  output logic [1:0]   d_digit,
  input  logic [1:0]   q_digit,
  input  logic         q_valid,
  output logic [N-1:0] q_plus,
  output logic [N-1:0] q_minus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned PadMax = DELTA + N;
  localparam int unsigned CntW   = $clog2(N + 1);
  localparam int unsigned PadW   = $clog2(PadMax + 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   xp_q, xp_d, xm_q, xm_d, dp_q, dp_d, dm_q, dm_d;
  logic [N-1:0]   qsp_q, qsp_d, qsm_q, qsm_d;
  logic [N-1:0]   qp_q, qp_d, qm_q, qm_d;
  logic [CntW-1:0] sent_q, sent_d, recv_q, recv_d;
  logic [PadW-1:0] pad_q, pad_d;
  logic [1:0]     xd_q, xd_d, dd_q, dd_d;
  logic           err_q, err_d;
  logic [1:0]     q_clean;
  logic           q_bad;

  // The illegal code 11 is streamed/stored as zero.
  function automatic logic [1:0] enc(logic p, logic m);
    return (p & m) ? 2'b00 : {p, m};
  endfunction

  assign q_bad   = &q_digit;
  assign q_clean = q_bad ? 2'b00 : q_digit;

  always_comb begin
    state_d = state_q;
    xp_d    = xp_q;
    xm_d    = xm_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    qsp_d   = qsp_q;
    qsm_d   = qsm_q;
    qp_d    = qp_q;
    qm_d    = qm_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    pad_d   = pad_q;
    xd_d    = xd_q;
    dd_d    = dd_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          xp_d    = x_plus;
          xm_d    = x_minus;
          dp_d    = d_plus;
          dm_d    = d_minus;
          qsp_d   = '0;
          qsm_d   = '0;
          sent_d  = '0;
          recv_d  = '0;
          pad_d   = '0;
          err_d   = 1'b0;
          state_d = StFeed;
        end
      end
      StFeed, StDrain: begin
        if (digit_req) begin
          if (state_q == StFeed) begin
            // Latched operands shift left so the next digit is always at the MSB.
            xd_d = enc(xp_q[N-1], xm_q[N-1]);
            dd_d = enc(dp_q[N-1], dm_q[N-1]);
            if ((xp_q[N-1] & xm_q[N-1]) | (dp_q[N-1] & dm_q[N-1])) err_d = 1'b1;
            xp_d   = xp_q << 1;
            xm_d   = xm_q << 1;
            dp_d   = dp_q << 1;
            dm_d   = dm_q << 1;
            sent_d = sent_q + CntW'(1);
            if (sent_q == CntW'(N - 1)) state_d = StDrain;
          end else begin
            xd_d = 2'b00;
            dd_d = 2'b00;
            if (pad_q != PadW'(PadMax)) pad_d = pad_q + PadW'(1);
          end
        end
        if (q_valid) begin
          qsp_d  = (qsp_q << 1) | N'(q_clean[1]);
          qsm_d  = (qsm_q << 1) | N'(q_clean[0]);
          recv_d = recv_q + CntW'(1);
          if (q_bad) err_d = 1'b1;
          if (recv_q == CntW'(N - 1)) begin
            state_d = StDone;
            qp_d    = qsp_d;
            qm_d    = qsm_d;
            xd_d    = 2'b00;
            dd_d    = 2'b00;
          end
        end
        // Divider never produced the full quotient within the padding budget.
        if (state_q == StDrain && digit_req && pad_d == PadW'(PadMax) && state_d != StDone) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a same-cycle start or completion.
    if (abort) begin
      state_d = StIdle;
      xd_d    = 2'b00;
      dd_d    = 2'b00;
      err_d   = err_q;
      qp_d    = qp_q;
      qm_d    = qm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      xp_q    <= '0;
      xm_q    <= '0;
      dp_q    <= '0;
      dm_q    <= '0;
      qsp_q   <= '0;
      qsm_q   <= '0;
      qp_q    <= '0;
      qm_q    <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      pad_q   <= '0;
      xd_q    <= 2'b00;
      dd_q    <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xp_q    <= xp_d;
      xm_q    <= xm_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      qsp_q   <= qsp_d;
      qsm_q   <= qsm_d;
      qp_q    <= qp_d;
      qm_q    <= qm_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      pad_q   <= pad_d;
      xd_q    <= xd_d;
      dd_q    <= dd_d;
      err_q   <= err_d;
    end
  end

  assign x_digit = xd_q;
  assign d_digit = dd_q;
  assign q_plus  = qp_q;
  assign q_minus = qm_q;
  assign err     = err_q;
  assign busy    = (state_q == StFeed) || (state_q == StDrain);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_online_sd_sequencer.sv
// Bench for online_sd_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transfer-level model.
module tb_online_sd_sequencer;

  localparam int N      = 4;
  localparam int DELTA  = 2;
  localparam int PADMAX = N + DELTA;

  logic         clk = 1'b0;
  logic         rst, start, abort, digit_req, q_valid;
  logic [N-1:0] x_plus, x_minus, d_plus, d_minus;
  logic [1:0]   q_digit;
  logic [1:0]   x_digit, d_digit;
  logic [N-1:0] q_plus, q_minus;
  logic         busy, done, err;

  int total = 0;
  int bad   = 0;

  online_sd_sequencer #(.N(N), .DELTA(DELTA)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .x_plus    (x_plus),
    .x_minus   (x_minus),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .digit_req (digit_req),
    .x_digit   (x_digit),
    .d_digit   (d_digit),
    .q_digit   (q_digit),
    .q_valid   (q_valid),
    .q_plus    (q_plus),
    .q_minus   (q_minus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level reference model ----------------
  // Digits are held as integers -1/0/+1; 2 marks an illegal 11 code.
  int           m_x[N], m_d[N];
  int           m_q[$];
  bit           m_active, m_donep, m_err;
  int           m_sent, m_pad, ex_x, ex_d;
  logic [N-1:0] m_qp, m_qm;

  function automatic int dec(logic p, logic m);
    if (p && m) return 2;
    return p ? 1 : (m ? -1 : 0);
  endfunction

  function automatic logic [1:0] enc_v(int v);
    return (v == 1) ? 2'b10 : ((v == -1) ? 2'b01 : 2'b00);
  endfunction

  task automatic model_step();
    bit pad_now;
    int pos;
    if (rst) begin
      m_active = 0; m_donep = 0; m_err = 0; m_sent = 0; m_pad = 0;
      m_q.delete(); ex_x = 0; ex_d = 0; m_qp = '0; m_qm = '0;
      return;
    end
    if (abort) begin
      m_active = 0; m_donep = 0; ex_x = 0; ex_d = 0;
      return;
    end
    if (m_donep) begin
      m_donep = 0;
      return;
    end
    if (!m_active) begin
      if (start) begin
        for (int i = 0; i < N; i++) begin
          m_x[i] = dec(x_plus[i], x_minus[i]);
          m_d[i] = dec(d_plus[i], d_minus[i]);
        end
        m_sent = 0; m_pad = 0; m_q.delete(); m_err = 0; m_active = 1;
      end
      return;
    end
    pad_now = 0;
    if (digit_req) begin
      if (m_sent < N) begin
        pos  = N - 1 - m_sent;
        ex_x = (m_x[pos] == 2) ? 0 : m_x[pos];
        ex_d = (m_d[pos] == 2) ? 0 : m_d[pos];
        if (m_x[pos] == 2 || m_d[pos] == 2) m_err = 1;
        m_sent++;
      end else begin
        ex_x = 0; ex_d = 0; pad_now = 1;
        if (m_pad < PADMAX) m_pad++;
      end
    end
    if (q_valid) begin
      if (q_digit == 2'b11) begin
        m_err = 1;
        m_q.push_back(0);
      end else begin
        m_q.push_back(dec(q_digit[1], q_digit[0]));
      end
    end
    if (m_q.size() == N) begin
      m_active = 0; m_donep = 1; ex_x = 0; ex_d = 0;
      m_qp = '0; m_qm = '0;
      for (int i = 0; i < N; i++) begin
        if (m_q[i] == 1)  m_qp[N-1-i] = 1'b1;
        if (m_q[i] == -1) m_qm[N-1-i] = 1'b1;
      end
    end else if (pad_now && m_pad == PADMAX) begin
      m_err = 1; m_active = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("x_digit", 32'(x_digit), 32'(enc_v(ex_x)));
    check("d_digit", 32'(d_digit), 32'(enc_v(ex_d)));
    check("q_plus",  32'(q_plus),  32'(m_qp));
    check("q_minus", 32'(q_minus), 32'(m_qm));
    check("busy",    32'(busy),    32'(m_active));
    check("done",    32'(done),    32'(m_donep));
    check("err",     32'(err),     32'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; digit_req = 0; q_valid = 0; q_digit = 2'b00;
  endtask

  initial begin
    logic [1:0] xs[6];
    logic [1:0] qs[4];
    int qdiv;
    rst = 1; idle_inputs();
    x_plus = '0; x_minus = '0; d_plus = '0; d_minus = '0;
    cyc(2);
    rst = 0;
    cyc();
    check("rst_x", 32'(x_digit), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);

    // Stream and collect.
    x_plus = 4'b1001; x_minus = 4'b0010; d_plus = 4'b0110; d_minus = 4'b0001;
    start = 1; cyc(); start = 0;
    check("feed_busy", 32'(busy), 1);
    xs = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    digit_req = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("stream_x", 32'(x_digit), 32'(xs[i]));
    end
    digit_req = 0;
    qs = '{2'b10, 2'b00, 2'b01, 2'b01};
    q_valid = 1;
    for (int i = 0; i < 4; i++) begin
      q_digit = qs[i];
      cyc();
    end
    q_valid = 0;
    check("collect_done", 32'(done), 1);
    check("collect_busy", 32'(busy), 0);
    check("collect_qp", 32'(q_plus), 32'(4'b1000));
    check("collect_qm", 32'(q_minus), 32'(4'b0011));
    cyc();
    check("done_one_cycle", 32'(done), 0);

    // Encoding errors.
    x_plus = '0; x_minus = '0; d_plus = 4'b0100; d_minus = 4'b0100;
    start = 1; cyc(); start = 0;
    digit_req = 1; cyc(2); digit_req = 0;
    check("bad_d_digit", 32'(d_digit), 0);
    check("bad_d_err", 32'(err), 1);
    qs = '{2'b11, 2'b10, 2'b10, 2'b10};
    q_valid = 1;
    for (int i = 0; i < 4; i++) begin
      q_digit = qs[i];
      cyc();
    end
    q_valid = 0;
    check("bad_q_err", 32'(err), 1);
    check("bad_q_qp", 32'(q_plus), 32'(4'b0111));
    check("bad_q_qm", 32'(q_minus), 32'(4'b0000));
    cyc();

    // Abort after two digits; the new start also clears err.
    x_plus = 4'b1111; x_minus = '0; d_plus = '0; d_minus = '0;
    start = 1; cyc(); start = 0;
    check("start_clears_err", 32'(err), 0);
    digit_req = 1; cyc(2); digit_req = 0;
    check("pre_abort_x", 32'(x_digit), 32'(2'b10));
    abort = 1; cyc(); abort = 0;
    check("abort_busy", 32'(busy), 0);
    check("abort_x", 32'(x_digit), 0);
    check("abort_done", 32'(done), 0);
    check("abort_qp", 32'(q_plus), 32'(4'b0111));

    // Padding timeout: 4 digits then 6 padding requests with no quotient.
    x_plus = 4'b1010; x_minus = 4'b0101;
    start = 1; cyc(); start = 0;
    digit_req = 1; cyc(9);
    check("pre_timeout_busy", 32'(busy), 1);
    check("pre_timeout_err", 32'(err), 0);
    cyc(); digit_req = 0;
    check("timeout_err", 32'(err), 1);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_done", 32'(done), 0);
    cyc();

    // Reset during DRAIN with a simultaneous start.
    start = 1; cyc(); start = 0;
    digit_req = 1; cyc(5); digit_req = 0;
    check("drain_busy", 32'(busy), 1);
    rst = 1; start = 1; cyc(); rst = 0; start = 0;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_qp", 32'(q_plus), 0);
    check("rst_mid_err", 32'(err), 0);
    cyc();
    // Clean transfer with digit_req and q_valid in the same cycles.
    x_plus = 4'b0011; x_minus = 4'b1100;
    start = 1; cyc(); start = 0;
    qs = '{2'b01, 2'b10, 2'b00, 2'b10};
    digit_req = 1; q_valid = 1;
    for (int i = 0; i < 4; i++) begin
      q_digit = qs[i];
      cyc();
    end
    idle_inputs();
    check("clean_done", 32'(done), 1);
    check("clean_qp", 32'(q_plus), 32'(4'b0101));
    check("clean_qm", 32'(q_minus), 32'(4'b1000));
    check("clean_err", 32'(err), 0);
    cyc();

    // Randomized traffic with a varying quotient arrival rate.
    for (int i = 0; i < 3000; i++) begin
      qdiv      = (i / 500) % 5;
      rst       = ($urandom_range(0, 199) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      start     = ($urandom_range(0, 3) == 0);
      digit_req = 1'($urandom_range(0, 1));
      q_valid   = ($urandom_range(0, qdiv) == 0);
      q_digit   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      x_plus    = N'($urandom);
      x_minus   = N'($urandom & $urandom);
      d_plus    = N'($urandom);
      d_minus   = N'($urandom & $urandom);
      cyc();
    end
    rst = 0; idle_inputs();
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
